led_bargraph_meter: RTL

//  Registered, parametrised LED bar-graph meter for the ultrasonic ranging path.

---
 rtl/led_bargraph_meter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/led_bargraph_meter.sv
// led_bargraph_meter
//   Bar-graph distance meter for the ultrasonic ranging path. Block-averages
//   2**AVG_LOG2 valid distance samples and drives an N_LEDS bar (closer = more
//   LEDs), with a peak-hold marker, a blinking proximity warning and a
//   stale-data blank-out.
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   distance   distance sample, cm (qualified by dist_valid)
//   dist_valid one-cycle strobe, distance valid this cycle
//   LEDR       LED drive, bit 0 = first LED lit
//   avg_dist   last completed average
//   level      LEDs lit by the bar, marker excluded
//   too_close  high while in the warning state
//   stale      high while no samples have arrived for TIMEOUT_CYC cycles
module led_bargraph_meter #(
  parameter int N_LEDS      = 18,
  parameter int DIST_W      = 12,
  parameter int STEP_CM     = 10,
  parameter int AVG_LOG2    = 2,
  parameter int CLOSE_CM    = 10,
  parameter int HOLD_CYC    = 25000000,
  parameter int BLINK_CYC   = 6250000,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DIST_W-1:0]            distance,
  input  logic                         dist_valid,
  output logic [N_LEDS-1:0]            LEDR,
  output logic [DIST_W-1:0]            avg_dist,
  output logic [$clog2(N_LEDS+1)-1:0]  level,
  output logic                         too_close,
  output logic                         stale
);

  localparam int LVL_W  = $clog2(N_LEDS+1);
  localparam int ACC_W  = DIST_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC+1);
  localparam int HOLD_W = $clog2(HOLD_CYC+1);
  localparam int BLK_W  = $clog2(BLINK_CYC+1);

  typedef enum logic [1:0] {S_WAIT, S_SHOW, S_WARN, S_STALE} state_t;

  state_t             state, state_n;
  logic [ACC_W-1:0]   acc, acc_sum;
  logic [CNT_W-1:0]   cnt;
  logic               last, avg_vld, timeout_hit, avg_close;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [DIST_W-1:0]  q;
  logic [LVL_W-1:0]   lvl_calc;
  logic [LVL_W-1:0]   level_n, peak_lvl, peak_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [BLK_W-1:0]   blink_cnt, blink_cnt_n;
  logic               blink_on, blink_on_n;
  logic [N_LEDS-1:0]  led_n;

  // ---------------- averaging ----------------
  assign acc_sum     = acc + ACC_W'(distance);
  assign last        = (cnt == CNT_W'((1 << AVG_LOG2) - 1));
  // a valid on the expiry cycle wins, so timeout needs an idle input
  assign timeout_hit = !dist_valid && (idle_cnt >= IDLE_W'(TIMEOUT_CYC-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      avg_dist <= '0;
      avg_vld  <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      if (timeout_hit) begin
        acc <= '0;
        cnt <= '0;
      end else if (dist_valid) begin
        if (last) begin
          avg_dist <= DIST_W'(acc_sum >> AVG_LOG2);
          acc      <= '0;
          cnt      <= '0;
          avg_vld  <= 1'b1;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // saturating idle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   idle_cnt <= '0;
    else if (dist_valid)                          idle_cnt <= '0;
    else if (idle_cnt != IDLE_W'(TIMEOUT_CYC))    idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  // ---------------- level from the average ----------------
  assign q         = avg_dist / DIST_W'(STEP_CM);
  assign lvl_calc  = (32'(q) >= N_LEDS) ? '0 : LVL_W'(N_LEDS - 32'(q));
  assign avg_close = (avg_dist < DIST_W'(CLOSE_CM));

  // ---------------- next state / outputs ----------------
  always_comb begin
    state_n     = state;
    level_n     = level;
    peak_n      = peak_lvl;
    hold_n      = hold_cnt;
    blink_cnt_n = blink_cnt;
    blink_on_n  = blink_on;
    led_n       = '0;

    if (avg_vld) level_n = lvl_calc;

    case (state)
      S_WAIT, S_SHOW: if (avg_vld) state_n = avg_close ? S_WARN : S_SHOW;
      S_WARN:         if (avg_vld && !avg_close) state_n = S_SHOW;
      S_STALE:        if (dist_valid) state_n = S_WAIT;
      default:        state_n = S_WAIT;
    endcase
    if (timeout_hit) state_n = S_STALE;

    // peak hold tracks the registered level; marker drops on the cycle the
    // timer would reach zero, giving HOLD_CYC cycles of marker
    if (state == S_SHOW) begin
      if (level >= peak_lvl) begin
        peak_n = level;
        hold_n = HOLD_W'(HOLD_CYC);
      end else if (hold_cnt <= HOLD_W'(1)) begin
        peak_n = level;
        hold_n = '0;
      end else begin
        hold_n = hold_cnt - HOLD_W'(1);
      end
    end
    if (timeout_hit) begin
      peak_n = '0;
      hold_n = '0;
    end

    // blink restarts in the ON phase on every entry into WARN
    if (state_n == S_WARN && state != S_WARN) begin
      blink_cnt_n = '0;
      blink_on_n  = 1'b1;
    end else if (state == S_WARN) begin
      if (blink_cnt == BLK_W'(BLINK_CYC-1)) begin
        blink_cnt_n = '0;
        blink_on_n  = !blink_on;
      end else begin
        blink_cnt_n = blink_cnt + BLK_W'(1);
      end
    end

    // LEDR is registered from the values being loaded this edge, so the bar
    // and marker line up with level/peak as seen after the edge
    case (state_n)
      S_SHOW: begin
        for (int i = 0; i < N_LEDS; i++) begin
          led_n[i] = (i < int'(level_n)) ||
                     ((peak_n > level_n) && (int'(peak_n) == i + 1));
        end
      end
      S_WARN:  led_n = {N_LEDS{blink_on_n}};
      default: led_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_WAIT;
      level     <= '0;
      peak_lvl  <= '0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b0;
      LEDR      <= '0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      peak_lvl  <= peak_n;
      hold_cnt  <= hold_n;
      blink_cnt <= blink_cnt_n;
      blink_on  <= blink_on_n;
      LEDR      <= led_n;
    end
  end

  assign too_close = (state == S_WARN);
  assign stale     = (state == S_STALE);

endmodule
